if_fetch_unit: RTL and testbench

- Instruction-fetch stage core: program counter, next-PC select mux, PC+4 adder, word-addressed instruction memory and the IF/ID pipeline register.
- Sits at the head of the 5-stage MIPS pipeline. Feeds the ID stage with the fetched instruction and its PC+4.
- Takes the sequential address (MUX_OPT_0) and the branch/jump target (MUX_OPT_1) from later stages.

---
 rtl/if_fetch_unit_if.sv | 58 +++++
 rtl/if_fetch_unit.sv | 100 ++++++++++
 tb/tb_if_fetch_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Purpose : bundles the fetch unit's next-PC inputs, program-load port and IF/ID outputs.
// Latency : none (wires only).
// Backpressure : STALL is carried here; it freezes the fetch unit, there is no ready/valid pair.
//
// Optional feature macro: IF_ID_FLUSH_EN adds the FLUSH signal.
// Modports:
//   master - upstream/testbench side: drives next-PC options, select, stall and
//            program-load writes; observes PC and IF/ID outputs.
//   slave  - fetch unit side.
interface if_fetch_unit_if #(
    parameter int unsigned IMEM_AW = 8
);
    logic [31:0]        MUX_OPT_0;
    logic [31:0]        MUX_OPT_1;
    logic               PC_SRC;
    logic               STALL;
`ifdef IF_ID_FLUSH_EN
    logic               FLUSH;
`endif
    logic               IMEM_WE;
    logic [IMEM_AW-1:0] IMEM_WADDR;
    logic [31:0]        IMEM_WDATA;
    logic [31:0]        PC_OUT;
    logic [31:0]        NEXT_INS_ADR_OUT;
    logic [31:0]        CUR_INS_OUT;

    modport master (
`ifdef IF_ID_FLUSH_EN
        output FLUSH,
`endif
        output MUX_OPT_0,
        output MUX_OPT_1,
        output PC_SRC,
        output STALL,
        output IMEM_WE,
        output IMEM_WADDR,
        output IMEM_WDATA,
        input  PC_OUT,
        input  NEXT_INS_ADR_OUT,
        input  CUR_INS_OUT
    );

    modport slave (
`ifdef IF_ID_FLUSH_EN
        input  FLUSH,
`endif
        input  MUX_OPT_0,
        input  MUX_OPT_1,
        input  PC_SRC,
        input  STALL,
        input  IMEM_WE,
        input  IMEM_WADDR,
        input  IMEM_WDATA,
        output PC_OUT,
        output NEXT_INS_ADR_OUT,
        output CUR_INS_OUT
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Purpose : MIPS IF stage - PC register, next-PC mux, PC+4 adder, word-addressed imem, IF/ID register.
// Latency : instruction at PC appears on CUR_INS_OUT one edge after PC holds it.
// Backpressure : STALL=1 holds PC and IF/ID; redirects presented during a stall are dropped.
//
// Ports:
//   CLK  - rising-edge clock
//   RST  - synchronous active-high reset (PC <= RESET_PC, IF/ID <= NOP bubble)
//   bus  - if_fetch_unit_if.slave: MUX_OPT_0/1, PC_SRC, STALL, IMEM_WE/WADDR/WDATA in;
//          PC_OUT, NEXT_INS_ADR_OUT, CUR_INS_OUT out
// Optional feature macro: IF_ID_FLUSH_EN - adds FLUSH, which zeroes IF/ID and
// forces a PC update even while STALL is asserted.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned IMEM_AW    = $clog2(IMEM_DEPTH)
) (
    input  logic            CLK,
    input  logic            RST,
    if_fetch_unit_if.slave  bus
);

    // Instruction storage. Not touched by reset so a program loaded while
    // the core is held in reset survives the release.
    logic [31:0] imem [IMEM_DEPTH];

    logic [31:0]        pc_q, pc_d;
    logic [31:0]        next_ins_adr_q, next_ins_adr_d;
    logic [31:0]        cur_ins_q, cur_ins_d;

    logic [IMEM_AW-1:0] fetch_idx;
    logic [31:0]        fetch_word;
    logic [31:0]        pc_plus4;
    logic [31:0]        pc_mux;
    logic               pc_advance;
    logic               ifid_load;
    logic               ifid_bubble;

    // Byte address -> word index. Low two bits are dropped (misaligned PCs
    // fetch the aligned word) and high bits are dropped (address wraps
    // modulo IMEM_DEPTH words).
    assign fetch_idx  = pc_q[IMEM_AW+1:2];
    assign fetch_word = imem[fetch_idx];
    assign pc_plus4   = pc_q + 32'd4;
    assign pc_mux     = bus.PC_SRC ? bus.MUX_OPT_1 : bus.MUX_OPT_0;

`ifdef IF_ID_FLUSH_EN
    // Flush wins over stall: the redirect that caused the flush must be
    // taken immediately, and the IF/ID slot becomes a bubble.
    assign pc_advance  = !bus.STALL || bus.FLUSH;
    assign ifid_bubble = bus.FLUSH;
`else
    assign pc_advance  = !bus.STALL;
    assign ifid_bubble = 1'b0;
`endif
    assign ifid_load = !bus.STALL;

    always_comb begin
        pc_d           = pc_q;
        next_ins_adr_d = next_ins_adr_q;
        cur_ins_d      = cur_ins_q;

        if (pc_advance) begin
            pc_d = pc_mux;
        end

        if (ifid_bubble) begin
            next_ins_adr_d = 32'd0;
            cur_ins_d      = 32'd0;
        end else if (ifid_load) begin
            next_ins_adr_d = pc_plus4;
            // Read of the pre-edge memory contents: a write to the same word
            // at this edge is only seen by the following fetch.
            cur_ins_d      = fetch_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q           <= RESET_PC;
            next_ins_adr_q <= 32'd0;
            cur_ins_q      <= 32'd0;
        end else begin
            pc_q           <= pc_d;
            next_ins_adr_q <= next_ins_adr_d;
            cur_ins_q      <= cur_ins_d;
        end
    end

    // Program-load port; independent of RST and STALL.
    always_ff @(posedge CLK) begin
        if (bus.IMEM_WE) begin
            imem[bus.IMEM_WADDR] <= bus.IMEM_WDATA;
        end
    end

    assign bus.PC_OUT           = pc_q;
    assign bus.NEXT_INS_ADR_OUT = next_ins_adr_q;
    assign bus.CUR_INS_OUT      = cur_ins_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.IMEM_AW(8)) bus ();

    if_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (256)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pc_src;
        logic        stall;
        logic [31:0] opt1;
        logic        we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exp_pc;
        logic [31:0] exp_nia;
        logic [31:0] exp_cur;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic src, input logic stl, input logic [31:0] o1,
                                input logic we, input logic [7:0] wa, input logic [31:0] wd,
                                input logic [31:0] pc, input logic [31:0] nia,
                                input logic [31:0] cur);
        vec_t v;
        v.pc_src = src; v.stall = stl; v.opt1 = o1;
        v.we = we; v.waddr = wa; v.wdata = wd;
        v.exp_pc = pc; v.exp_nia = nia; v.exp_cur = cur;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [31:0] pc,
                          input logic [31:0] nia, input logic [31:0] cur);
        check({tag, "_pc"},  bus.PC_OUT,           pc);
        check({tag, "_nia"}, bus.NEXT_INS_ADR_OUT, nia);
        check({tag, "_cur"}, bus.CUR_INS_OUT,      cur);
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it and
    // inputs are changed there too, well away from the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic imem_write(input logic [7:0] a, input logic [31:0] d);
        bus.IMEM_WE    = 1'b1;
        bus.IMEM_WADDR = a;
        bus.IMEM_WDATA = d;
        step();
        bus.IMEM_WE    = 1'b0;
    endtask

    initial begin
        // Fetch sequence from PC=0 after reset. MUX_OPT_0 is always PC_OUT+4.
        vecs[0]  = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h4,         32'h4,   32'h2001_0005);
        vecs[1]  = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h8,         32'h8,   32'h2002_0007);
        // Branch at PC=8 to 0x40
        vecs[2]  = mk(1, 0, 32'h40,        0, 8'd0, 32'h0,         32'h40,        32'hC,   32'h0022_1820);
        vecs[3]  = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h44,        32'h44,  32'hDEAD_BEEF);
        // Jump to 4, then stall three edges (one with a redirect that must be dropped)
        vecs[4]  = mk(1, 0, 32'h4,         0, 8'd0, 32'h0,         32'h4,         32'h48,  32'h0);
        vecs[5]  = mk(1, 1, 32'h80,        0, 8'd0, 32'h0,         32'h4,         32'h48,  32'h0);
        vecs[6]  = mk(0, 1, 32'h0,         0, 8'd0, 32'h0,         32'h4,         32'h48,  32'h0);
        vecs[7]  = mk(0, 1, 32'h0,         0, 8'd0, 32'h0,         32'h4,         32'h48,  32'h0);
        vecs[8]  = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h8,         32'h8,   32'h2002_0007);
        // Misaligned PC 6, wrap at 0x400, PC+4 wrap at FFFF_FFFC
        vecs[9]  = mk(1, 0, 32'h6,         0, 8'd0, 32'h0,         32'h6,         32'hC,   32'h0022_1820);
        vecs[10] = mk(1, 0, 32'h400,       0, 8'd0, 32'h0,         32'h400,       32'hA,   32'h2002_0007);
        vecs[11] = mk(1, 0, 32'hFFFF_FFFC, 0, 8'd0, 32'h0,         32'hFFFF_FFFC, 32'h404, 32'h2001_0005);
        vecs[12] = mk(1, 0, 32'h4,         0, 8'd0, 32'h0,         32'h4,         32'h0,   32'hCAFE_F00D);
        // Same-cycle write/fetch of word 1 at PC=4: old word captured
        vecs[13] = mk(0, 0, 32'h0,         1, 8'd1, 32'h1111_1111, 32'h8,         32'h8,   32'h2002_0007);
        vecs[14] = mk(1, 0, 32'h4,         0, 8'd0, 32'h0,         32'h4,         32'hC,   32'h0022_1820);
        vecs[15] = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h8,         32'h8,   32'h1111_1111);
        // Memory write lands even while stalled
        vecs[16] = mk(0, 1, 32'h0,         1, 8'd2, 32'h2222_2222, 32'h8,         32'h8,   32'h1111_1111);
        vecs[17] = mk(0, 0, 32'h0,         0, 8'd0, 32'h0,         32'hC,         32'hC,   32'h2222_2222);

        rst            = 1'b1;
        bus.MUX_OPT_0  = 32'h10;
        bus.MUX_OPT_1  = 32'h0;
        bus.PC_SRC     = 1'b0;
        bus.STALL      = 1'b0;
        bus.IMEM_WE    = 1'b0;
        bus.IMEM_WADDR = 8'd0;
        bus.IMEM_WDATA = 32'h0;
`ifdef IF_ID_FLUSH_EN
        bus.FLUSH      = 1'b0;
`endif

        // Program load while held in reset: clear everything, then the test words.
        for (int i = 0; i < 256; i++) imem_write(i[7:0], 32'h0);
        imem_write(8'd0,   32'h2001_0005);
        imem_write(8'd1,   32'h2002_0007);
        imem_write(8'd2,   32'h0022_1820);
        imem_write(8'd16,  32'hDEAD_BEEF);
        imem_write(8'd255, 32'hCAFE_F00D);

        // Two more reset edges with MUX_OPT_0=0x10 and PC_SRC=0
        step();
        step();
        check3("reset", 32'h0, 32'h0, 32'h0);

        rst = 1'b0;
        for (int v = 0; v < NVEC; v++) begin
            bus.MUX_OPT_0  = bus.PC_OUT + 32'd4;
            bus.MUX_OPT_1  = vecs[v].opt1;
            bus.PC_SRC     = vecs[v].pc_src;
            bus.STALL      = vecs[v].stall;
            bus.IMEM_WE    = vecs[v].we;
            bus.IMEM_WADDR = vecs[v].waddr;
            bus.IMEM_WDATA = vecs[v].wdata;
            step();
            check3($sformatf("vec%0d", v), vecs[v].exp_pc, vecs[v].exp_nia, vecs[v].exp_cur);
        end
        bus.IMEM_WE = 1'b0;
        bus.STALL   = 1'b0;
        bus.PC_SRC  = 1'b0;

        // Mid-run reset, with a memory write landing during reset and a
        // stall asserted: reset still wins, the write still happens.
        rst            = 1'b1;
        bus.STALL      = 1'b1;
        bus.IMEM_WE    = 1'b1;
        bus.IMEM_WADDR = 8'd3;
        bus.IMEM_WDATA = 32'h3333_3333;
        step();
        check3("rst2", 32'h0, 32'h0, 32'h0);
        rst         = 1'b0;
        bus.STALL   = 1'b0;
        bus.IMEM_WE = 1'b0;
        bus.PC_SRC  = 1'b1;
        bus.MUX_OPT_1 = 32'hC;
        step();
        check3("post_rst_a", 32'hC, 32'h4, 32'h2001_0005);
        bus.PC_SRC    = 1'b0;
        bus.MUX_OPT_0 = bus.PC_OUT + 32'd4;
        step();
        check3("post_rst_b", 32'h10, 32'h10, 32'h3333_3333);

`ifdef IF_ID_FLUSH_EN
        // Flush together with stall: PC takes the redirect, IF/ID becomes a bubble.
        bus.FLUSH     = 1'b1;
        bus.STALL     = 1'b1;
        bus.PC_SRC    = 1'b1;
        bus.MUX_OPT_1 = 32'h8;
        step();
        check3("flush", 32'h8, 32'h0, 32'h0);
        bus.FLUSH     = 1'b0;
        bus.STALL     = 1'b0;
        bus.PC_SRC    = 1'b0;
        bus.MUX_OPT_0 = bus.PC_OUT + 32'd4;
        step();
        check3("post_flush", 32'hC, 32'hC, 32'h2222_2222);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
